// File: rtl/phy_tx_lane_serializer_if.sv
// Lane-group input bus and serial slot output bus of the PHY TX lane serializer.
// The master side drives groups and slot acceptance; the slave side is the serializer.
interface phy_tx_lane_serializer_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    localparam int PTR_W = $clog2(LANES);

    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        in_valid;
    logic                    in_push;
    logic                    in_ready;
    logic                    mode;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic [PTR_W-1:0]        out_lane;
    logic                    out_ready;
    logic                    err_drop;

    modport master (
        output in_data, in_valid, in_push, mode, out_ready,
        input  in_ready, out_data, out_valid, out_lane, err_drop
    );

    modport slave (
        input  in_data, in_valid, in_push, mode, out_ready,
        output in_ready, out_data, out_valid, out_lane, err_drop
    );
endinterface

// File: rtl/phy_tx_lane_serializer.sv
// PHY TX lane serializer: captures a group of LANES lanes and emits them one
// slot per cycle on a ready/valid stream. TDM mode walks every lane and shows
// the last valid payload of an invalid lane with valid low; compact mode walks
// only the lanes flagged valid in the group.

// Protocol properties of the serial output; kept apart from the datapath.
module phy_tx_lane_serializer_chk #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int PTR_W  = 2
) (
    input logic              clk,
    input logic              reset,
    input logic [DATA_W-1:0] out_data,
    input logic              out_valid,
    input logic [PTR_W-1:0]  out_lane,
    input logic              out_ready,
    input logic              err_drop,
    input logic              in_ready
);
    // A stalled valid slot keeps its payload and lane until taken.
    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_lane)));

    // The drop flag only clears through reset.
    a_err_sticky: assert property (@(posedge clk) disable iff (reset)
        err_drop |=> err_drop);

    // The lane index never points past the last lane.
    a_lane_range: assert property (@(posedge clk) disable iff (reset)
        (int'(out_lane) < LANES));

    // A new group cannot be taken while a valid slot is stalled.
    a_no_ready_on_stall: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |-> !in_ready);
endmodule

module phy_tx_lane_serializer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input logic                     clk,
    input logic                     reset,
    phy_tx_lane_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(LANES);

    // Lowest set lane of a mask; 0 when the mask is empty.
    function automatic logic [PTR_W-1:0] f_lowest(input logic [LANES-1:0] mask);
        logic [PTR_W-1:0] r_sel;
        r_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r_sel = PTR_W'(i);
            end
        end
        return r_sel;
    endfunction

    // Next set lane strictly above ptr, ascending; 0 when none remains.
    function automatic logic [PTR_W-1:0] f_next_above(input logic [LANES-1:0] mask,
                                                      input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] r_sel;
        r_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                r_sel = PTR_W'(i);
            end
        end
        return r_sel;
    endfunction

    logic [DATA_W-1:0] r_buf  [LANES];
    logic [DATA_W-1:0] r_hold [LANES];
    logic [LANES-1:0]  r_lane_valid;
    logic [LANES-1:0]  r_pend;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_mode;
    logic              r_err_drop;

    logic              w_empty;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
    logic [PTR_W-1:0]  w_out_lane;
    logic              w_retire;
    logic [LANES-1:0]  w_pend_after;
    logic              w_last;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drop;
    logic [PTR_W-1:0]  w_ptr_next;

    // Slot presentation, retire decision and group-accept handshake.
    always_comb begin
        w_empty     = (r_pend == '0);
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_out_lane  = '0;
        if (w_empty) begin
            w_out_valid = 1'b0;
            w_out_data  = '0;
            w_out_lane  = '0;
        end else if (r_mode) begin
            w_out_valid = 1'b1;
            w_out_data  = r_buf[r_ptr];
            w_out_lane  = r_ptr;
        end else begin
            w_out_valid = r_lane_valid[r_ptr];
            w_out_lane  = r_ptr;
            if (r_lane_valid[r_ptr]) begin
                w_out_data = r_buf[r_ptr];
            end else begin
                w_out_data = r_hold[r_ptr];
            end
        end

        // Invalid TDM slots retire without waiting on the downstream.
        w_retire     = !w_empty && (bus.out_ready || !w_out_valid);
        w_pend_after = r_pend & ~(LANES'(1'b1) << r_ptr);
        w_last       = (w_pend_after == '0);

        // Ready on the cycle the last slot retires gives gapless back-to-back groups.
        w_in_ready = !reset && (w_empty || (w_last && w_retire));
        w_accept   = bus.in_push && w_in_ready;
        w_drop     = bus.in_push && !w_in_ready;

        if (r_mode) begin
            w_ptr_next = f_next_above(w_pend_after, r_ptr);
        end else begin
            w_ptr_next = r_ptr + PTR_W'(1);
        end
    end

    // Group state: async clear, slot retire, then group accept overriding pend/ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[k]  <= '0;
                r_hold[k] <= '0;
            end
            r_lane_valid <= '0;
            r_pend       <= '0;
            r_ptr        <= '0;
            r_mode       <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end

            if (w_retire) begin
                r_pend <= w_pend_after;
                if (w_out_valid) begin
                    r_hold[r_ptr] <= r_buf[r_ptr];
                end
                if (w_last) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_ptr_next;
                end
            end

            // Accept only happens when idle or on the final retire, so it owns pend/ptr.
            if (w_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    r_buf[k] <= bus.in_data[k*DATA_W +: DATA_W];
                end
                r_lane_valid <= bus.in_valid;
                r_mode       <= bus.mode;
                if (bus.mode) begin
                    r_pend <= bus.in_valid;
                    r_ptr  <= f_lowest(bus.in_valid);
                end else begin
                    r_pend <= '1;
                    r_ptr  <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_lane  = w_out_lane;
    assign bus.err_drop  = r_err_drop;

    phy_tx_lane_serializer_chk #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .PTR_W  (PTR_W)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .out_data  (w_out_data),
        .out_valid (w_out_valid),
        .out_lane  (w_out_lane),
        .out_ready (bus.out_ready),
        .err_drop  (r_err_drop),
        .in_ready  (w_in_ready)
    );
endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Scoreboard bench for phy_tx_lane_serializer: a 4x8 instance driven with
// directed and random groups against a slot-list reference model, and an 8x16
// instance exercising gapless back-to-back TDM groups.
module tb_phy_tx_lane_serializer;
    localparam int DW  = 8;
    localparam int NL  = 4;
    localparam int DW8 = 16;
    localparam int NL8 = 8;

    typedef struct {
        int          lane;
        logic [15:0] data;
        logic        valid;
    } slot_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phy_tx_lane_serializer_if #(.DATA_W(DW),  .LANES(NL))  ifa ();
    phy_tx_lane_serializer_if #(.DATA_W(DW8), .LANES(NL8)) ifb ();

    phy_tx_lane_serializer #(.DATA_W(DW), .LANES(NL)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    phy_tx_lane_serializer #(.DATA_W(DW8), .LANES(NL8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    slot_t       q_a [$];
    slot_t       q_b [$];
    logic [DW-1:0] hold_a [NL];
    logic        err_a = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of one accepted group: the ordered list of slots it produces.
    task automatic model_group_a(input logic [NL*DW-1:0] d, input logic [NL-1:0] v, input logic m);
        slot_t s;
        for (int k = 0; k < NL; k++) begin
            s.lane  = k;
            s.valid = v[k];
            s.data  = 16'(v[k] ? d[k*DW +: DW] : hold_a[k]);
            if (!m || v[k]) begin
                if (m) s.valid = 1'b1;
                q_a.push_back(s);
            end
        end
    endtask

    // Monitor for the 4-lane instance: compare presented slot, ready and drop flag.
    logic  retire_a;
    logic  exp_ready_a;
    slot_t pop_a;
    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
            for (int k = 0; k < NL; k++) hold_a[k] = '0;
            err_a = 1'b0;
        end else begin
            retire_a = 1'b0;
            if (q_a.size() == 0) begin
                check("idle_outputs", 64'({ifa.out_valid, ifa.out_lane, ifa.out_data}), 64'(0));
            end else begin
                check("out_valid", 64'(ifa.out_valid), 64'(q_a[0].valid));
                check("out_lane",  64'(ifa.out_lane),  64'(q_a[0].lane));
                check("out_data",  64'(ifa.out_data),  64'(q_a[0].data));
                retire_a = !q_a[0].valid || ifa.out_ready;
            end
            exp_ready_a = (q_a.size() == 0) || (q_a.size() == 1 && retire_a);
            check("in_ready", 64'(ifa.in_ready), 64'(exp_ready_a));
            check("err_drop", 64'(ifa.err_drop), 64'(err_a));
            if (retire_a) begin
                pop_a = q_a.pop_front();
                if (pop_a.valid) hold_a[pop_a.lane] = pop_a.data[DW-1:0];
            end
            if (ifa.in_push && !exp_ready_a) err_a = 1'b1;
            if (ifa.in_push && exp_ready_a) model_group_a(ifa.in_data, ifa.in_valid, ifa.mode);
        end
    end

    // Monitor for the 8-lane instance: no gaps while slots are owed, in-order lanes/data.
    slot_t pop_b;
    always @(negedge clk) begin
        if (!reset && q_b.size() > 0) begin
            check("b_out_valid", 64'(ifb.out_valid), 64'(1));
            check("b_out_lane",  64'(ifb.out_lane),  64'(q_b[0].lane));
            check("b_out_data",  64'(ifb.out_data),  64'(q_b[0].data));
            if (ifb.out_ready) pop_b = q_b.pop_front();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [NL*DW-1:0] d, input logic [NL-1:0] v, input logic m);
        ifa.in_data  = d;
        ifa.in_valid = v;
        ifa.mode     = m;
        ifa.in_push  = 1'b1;
        @(posedge clk);
        #1;
        ifa.in_push  = 1'b0;
    endtask

    task automatic push_b_group();
        slot_t s;
        logic [DW8-1:0] val;
        slot_t grp [$];
        for (int k = 0; k < NL8; k++) begin
            val = DW8'($urandom);
            ifb.in_data[k*DW8 +: DW8] = val;
            s.lane  = k;
            s.data  = val;
            s.valid = 1'b1;
            grp.push_back(s);
        end
        ifb.in_valid = '1;
        ifb.mode     = 1'b0;
        ifb.in_push  = 1'b1;
        @(posedge clk);
        #1;
        ifb.in_push = 1'b0;
        foreach (grp[i]) q_b.push_back(grp[i]);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_data = '0; ifa.in_valid = '0; ifa.in_push = 1'b0; ifa.mode = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_data = '0; ifb.in_valid = '0; ifb.in_push = 1'b0; ifb.mode = 1'b0; ifb.out_ready = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset mid-group: two slots out, then reset clears outputs immediately.
        push_a({8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 1'b0);
        idle(2);
        reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(ifa.out_valid), 64'(0));
        check("rst_out_data",  64'(ifa.out_data),  64'(0));
        check("rst_out_lane",  64'(ifa.out_lane),  64'(0));
        check("rst_in_ready",  64'(ifa.in_ready),  64'(0));
        check("rst_err_drop",  64'(ifa.err_drop),  64'(0));
        idle(1);
        reset = 1'b0;
        idle(1);
        push_a({8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 1'b0);
        idle(5);

        // TDM hold, second group pushed back-to-back on the last retire.
        push_a({8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 1'b0);
        idle(3);
        push_a({8'hA4, 8'hA3, 8'hA2, 8'hA1}, 4'b0101, 1'b0);
        idle(5);

        // Compact skip, then compact empty group.
        push_a({8'hD4, 8'hD3, 8'hD2, 8'hD1}, 4'b1010, 1'b1);
        idle(3);
        push_a({8'h5A, 8'h5B, 8'h5C, 8'h5D}, 4'b0000, 1'b1);
        idle(2);

        // Backpressure on slot 1 for three cycles with a dropped push in the stall.
        push_a({8'h88, 8'h77, 8'h66, 8'h55}, 4'b1111, 1'b0);
        idle(1);
        ifa.out_ready = 1'b0;
        idle(1);
        push_a({8'hEE, 8'hEE, 8'hEE, 8'hEE}, 4'b1111, 1'b0);
        idle(1);
        ifa.out_ready = 1'b1;
        idle(5);

        // Clear the sticky drop flag, then random traffic.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        for (int c = 0; c < 600; c++) begin
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifa.in_data   = NL*DW'($urandom);
            ifa.in_valid  = NL'($urandom_range(0, 15));
            ifa.mode      = 1'($urandom_range(0, 1));
            ifa.in_push   = ($urandom_range(0, 2) == 0);
            idle(1);
        end
        ifa.in_push   = 1'b0;
        ifa.out_ready = 1'b1;
        idle(8);
        check("a_queue_drained", 64'(q_a.size()), 64'(0));

        // Wide instance: groups every LANES cycles with continuous output.
        for (int g = 0; g < 4; g++) begin
            push_b_group();
            idle(NL8 - 1);
        end
        idle(3);
        check("b_queue_drained", 64'(q_b.size()), 64'(0));
        check("b_err_drop",      64'(ifb.err_drop), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
